// File: rtl/traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_intersection_ctrl
//
// Purpose: fixed-time controller for a two-approach intersection (north-south
// and east-west) with all-red clearance, an optional pedestrian walk phase
// and a night/flash mode.
//
// Optional feature: define macro TLC_PED_EN to compile in the pedestrian
// logic (ped_pending register and WALK state). Without it ped_req is ignored
// and walk is tied low.
//
// Ports:
//   clk        in   single clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   ped_req    in   pedestrian request, a one-cycle pulse is enough
//   flash_req  in   level, night/flash mode request
//   ns_lights  out  {red,yellow,green} for north-south
//   ew_lights  out  {red,yellow,green} for east-west
//   walk       out  pedestrian walk indication
//   phase      out  current state encoding (debug view of the FSM)
//
// Handshake: none; inputs are sampled on every rising edge, and outputs are
// Moore outputs that are valid for the whole cycle following that edge.
// -----------------------------------------------------------------------------
module traffic_intersection_ctrl #(
   parameter int CNT_W         = 4,
   parameter int NS_GREEN_TIME = 8,
   parameter int EW_GREEN_TIME = 5,
   parameter int YELLOW_TIME   = 2,
   parameter int ALLRED_TIME   = 1,
   parameter int WALK_TIME     = 4,
   parameter int FLASH_TIME    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req,
   input  logic       flash_req,
   output logic [2:0] ns_lights,
   output logic [2:0] ew_lights,
   output logic       walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      ALLRED_N  = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      ALLRED_E  = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
      WALK      = 3'd6,
      FLASH     = 3'd7
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             blink, blink_n;
   logic             cnt_zero;

   // Every TIME lies in 1..2^CNT_W, so TIME-1 always fits in CNT_W bits.
   function automatic logic [CNT_W-1:0] load_of(input state_t s);
      case (s)
         NS_GREEN:  load_of = CNT_W'(NS_GREEN_TIME - 1);
         NS_YELLOW: load_of = CNT_W'(YELLOW_TIME - 1);
         EW_GREEN:  load_of = CNT_W'(EW_GREEN_TIME - 1);
         EW_YELLOW: load_of = CNT_W'(YELLOW_TIME - 1);
         WALK:      load_of = CNT_W'(WALK_TIME - 1);
         FLASH:     load_of = CNT_W'(FLASH_TIME - 1);
         default:   load_of = CNT_W'(ALLRED_TIME - 1);
      endcase
   endfunction

   assign cnt_zero = (cnt == '0);

`ifdef TLC_PED_EN
   logic ped_pending, ped_pending_n;
   logic ped_go;

   // A request arriving in the same cycle EW_YELLOW expires still counts.
   assign ped_go = ped_pending | ped_req;
`else
   logic ped_go;
   logic ped_req_unused;

   assign ped_go         = 1'b0;
   assign ped_req_unused = ped_req;
`endif

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ALLRED_N;
         cnt   <= CNT_W'(ALLRED_TIME - 1);
         blink <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         blink <= blink_n;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic. The counter only moves down while nonzero; at zero the
   // state's successor is chosen and the counter reloads for that successor
   // (FLASH reloads itself when it stays, which defines the blink period).
   // -------------------------------------------------------------------------
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      blink_n = blink;
      if (!cnt_zero) begin
         cnt_n = cnt - 1'b1;
      end else begin
         case (state)
            ALLRED_N:  state_n = flash_req ? FLASH : NS_GREEN;
            NS_GREEN:  state_n = NS_YELLOW;
            NS_YELLOW: state_n = ALLRED_E;
            ALLRED_E:  state_n = flash_req ? FLASH : EW_GREEN;
            EW_GREEN:  state_n = EW_YELLOW;
            EW_YELLOW: state_n = ped_go ? WALK : ALLRED_N;
            WALK:      state_n = ALLRED_N;
            FLASH: begin
               if (flash_req) begin
                  state_n = FLASH;
                  blink_n = ~blink;
               end else begin
                  state_n = ALLRED_N;
                  blink_n = 1'b0;
               end
            end
            default:   state_n = ALLRED_N;
         endcase
         if (state != FLASH) begin
            blink_n = 1'b0;
         end
         cnt_n = load_of(state_n);
      end
   end

`ifdef TLC_PED_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ped_pending <= 1'b0;
      end else begin
         ped_pending <= ped_pending_n;
      end
   end

   // Entering or sitting in WALK absorbs requests into the current walk;
   // entering FLASH drops any queued request.
   always_comb begin
      ped_pending_n = ped_pending;
      if ((state_n == WALK) || (state == WALK)) begin
         ped_pending_n = 1'b0;
      end else if ((state_n == FLASH) && (state != FLASH)) begin
         ped_pending_n = 1'b0;
      end else if (ped_req) begin
         ped_pending_n = 1'b1;
      end
   end
`endif

   // -------------------------------------------------------------------------
   // Moore output decode from state and blink only
   // -------------------------------------------------------------------------
   always_comb begin
      ns_lights = 3'b100;
      ew_lights = 3'b100;
      walk      = 1'b0;
      case (state)
         NS_GREEN:  ns_lights = 3'b001;
         NS_YELLOW: ns_lights = 3'b010;
         EW_GREEN:  ew_lights = 3'b001;
         EW_YELLOW: ew_lights = 3'b010;
         FLASH: begin
            ns_lights = {1'b0, blink, 1'b0};
            ew_lights = {blink, 2'b00};
         end
         WALK: begin
`ifdef TLC_PED_EN
            walk = 1'b1;
`else
            walk = 1'b0;
`endif
         end
         default: begin
            ns_lights = 3'b100;
            ew_lights = 3'b100;
         end
      endcase
   end

   assign phase = state;

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter CNT_W, default 4: phase counter width; every *_TIME parameter SHALL lie in 1..2^CNT_W.
REQ-002 Parameter NS_GREEN_TIME, default 8: NS green duration in cycles.
REQ-003 Parameter EW_GREEN_TIME, default 5: EW green duration in cycles.
REQ-004 Parameter YELLOW_TIME, default 2: yellow duration in cycles, both approaches.
REQ-005 Parameter ALLRED_TIME, default 1: all-red clearance duration in cycles.
REQ-006 Parameter WALK_TIME, default 4: pedestrian walk duration in cycles.
REQ-007 Parameter FLASH_TIME, default 3: half-period of flash blink in cycles.
REQ-008 clk  input  1  single clock; all state changes on rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 ped_req  input  1  pedestrian request; a one-cycle pulse is sufficient.
REQ-011 flash_req  input  1  level; night/flash mode request.
REQ-012 ns_lights  output  3  {red,yellow,green} for north-south.
REQ-013 ew_lights  output  3  {red,yellow,green} for east-west.
REQ-014 walk  output  1  pedestrian walk indication.
REQ-015 phase  output  3  current state encoding (REQ-017).

Function
REQ-016 Outputs SHALL be Moore outputs decoded combinationally from the state register and blink bit only.
REQ-017 States and phase encodings: ALLRED_N=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_E=3, EW_GREEN=4, EW_YELLOW=5, WALK=6, FLASH=7.
REQ-018 On entry to a state the counter SHALL load that state's TIME-1; it decrements each cycle; transition occurs on the edge where counter==0, so each state lasts exactly its TIME cycles.
REQ-019 Sequence: ALLRED_N(ALLRED_TIME)->NS_GREEN->NS_YELLOW->ALLRED_E(ALLRED_TIME)->EW_GREEN->EW_YELLOW->ALLRED_N.
REQ-020 Light decode: exactly one bit of ns_lights and one of ew_lights high in non-FLASH states; the approach not green/yellow SHALL show red; ALLRED_N, ALLRED_E, WALK show red on both.
REQ-021 At no time SHALL both approaches show green or yellow simultaneously.
REQ-022 FLASH entered only from ALLRED_N or ALLRED_E at counter==0 with flash_req=1; flash_req overrides the normal successor.
REQ-023 In FLASH: blink bit toggles every FLASH_TIME cycles; ns_lights={0,blink,0}, ew_lights={blink,0,0}; walk=0; blink=0 on entry.
REQ-024 FLASH exits to ALLRED_N only at a toggle boundary (counter==0) with flash_req=0; blink cleared on exit.
REQ-025 flash_req changes outside the REQ-022/REQ-024 sample points SHALL have no effect.
REQ-026 Counter arithmetic SHALL be unsigned CNT_W bits; counter never wraps below zero.

Reset
REQ-027 rst=1 at a rising edge SHALL, regardless of state or counter, set state=ALLRED_N, counter=ALLRED_TIME-1, blink=0, ped_pending=0.
REQ-028 Outputs after reset: ns_lights=3'b100, ew_lights=3'b100, walk=0, phase=0.
REQ-029 First edge with rst=0 is the first counted cycle of ALLRED_N.
REQ-030 rst SHALL dominate ped_req and flash_req in the same cycle.

Configuration
REQ-031 Macro TLC_PED_EN compiles in pedestrian logic: ped_pending register set by ped_req, WALK state used.
REQ-032 With TLC_PED_EN: EW_YELLOW at counter==0 goes to WALK if ped_pending=1 (or ped_req=1 that cycle), else ALLRED_N; WALK goes to ALLRED_N; walk=1 only in WALK.
REQ-033 With TLC_PED_EN: ped_pending cleared on the edge entering WALK; ped_req asserted while in WALK or on the entry edge is absorbed by the current walk; FLASH clears ped_pending on entry.
REQ-034 Without TLC_PED_EN: ped_req ignored, WALK unreachable, walk tied 0, no ped_pending register.

Verification
REQ-035 Defaults, no requests: rst 1 cycle then release -> phase 0,1,2,3,4,5 lasting 1,8,2,1,5,2 cycles; period 19 cycles repeats.
REQ-036 TLC_PED_EN, ped_req pulse during NS_GREEN -> after EW_YELLOW, WALK 4 cycles with walk=1 and both red, then ALLRED_N; next loop has no WALK.
REQ-037 flash_req held high from NS_GREEN -> FLASH entered at end of ALLRED_E; ns yellow and ew red toggle every 3 cycles, out of phase with off.
REQ-038 flash_req dropped mid-half-period -> FLASH held until counter==0, then ALLRED_N with blink=0.
REQ-039 rst asserted mid-EW_GREEN with ped_req=1 same cycle -> next cycle phase=0, both red, ped_pending=0, no WALK in following loop.
REQ-040 Every cycle of all scenarios: assertion REQ-021 holds; phase matches light decode.
